imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. Accepts one 32-bit RISC-V instruction per cycle over a valid/ready handshake and fully decodes the opcode into format R/I/S/B/U/J. It emits the sign-extended XLEN-bit immediate, the format code and an illegal flag, and holds them in a two-entry skid buffer so that back-pressure from execute never creates a combinational ready path. It also keeps a saturating count of illegal opcodes for debug.

---
 rtl/imm_pkg.sv | 30 +++
 rtl/imm_decode.sv | 68 ++++++
 rtl/imm_gen_pipe.sv | 122 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared format codes, opcode constants and skid-buffer state encoding
package imm_pkg;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_BAD = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RISC-V opcode decode and immediate extraction
// Ports:
//   instruction  in   32    raw instruction
//   immediate    out  XLEN  sign-extended immediate (0 for R and BAD)
//   fmt          out  3     format code (FMT_*)
//   illegal      out  1     opcode not recognised
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] immediate,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic        s;
  logic [31:0] imm32;

  assign s = instruction[31];

  // Every legal opcode ends in 2'b11, so encodings with other low bits fall to default.
  always_comb begin
    imm32   = 32'd0;
    fmt     = FMT_BAD;
    illegal = 1'b1;
    case (instruction[6:0])
      OP_LOAD, OP_IMM, OP_IMM_32, OP_JALR: begin
        fmt     = FMT_I;
        illegal = 1'b0;
        imm32   = {{20{s}}, instruction[31:20]};
      end
      OP_STORE: begin
        fmt     = FMT_S;
        illegal = 1'b0;
        imm32   = {{20{s}}, instruction[31:25], instruction[11:7]};
      end
      OP_BRANCH: begin
        fmt     = FMT_B;
        illegal = 1'b0;
        imm32   = {{19{s}}, s, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt     = FMT_U;
        illegal = 1'b0;
        imm32   = {instruction[31:12], 12'd0};
      end
      OP_JAL: begin
        fmt     = FMT_J;
        illegal = 1'b0;
        imm32   = {{11{s}}, s, instruction[19:12], instruction[20], instruction[30:21], 1'b0};
      end
      OP_OP, OP_OP_32: begin
        fmt     = FMT_R;
        illegal = 1'b0;
      end
      default: begin
        fmt     = FMT_BAD;
        illegal = 1'b1;
      end
    endcase
  end

  // All formats fit in 32 bits; widen to XLEN by sign extension from bit 31.
  assign immediate = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with two-entry skid buffer
// Ports:
//   clk, reset      in   rising-edge clock, synchronous active-high reset
//   in_valid        in   instruction present
//   in_ready        out  block can accept (registered state only)
//   instruction     in   32-bit raw instruction
//   out_valid       out  result present in head register
//   out_ready       in   consumer accepts
//   immediate       out  XLEN sign-extended immediate
//   fmt             out  format code
//   illegal         out  opcode not recognised
//   illegal_count   out  saturating count of accepted illegal instructions
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immediate,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  skid_state_t state, state_next;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  logic [XLEN-1:0] skid_imm;
  logic [2:0]      skid_fmt;
  logic            skid_illegal;

  logic accept, drain;
  logic load_head_new, load_skid, load_head_skid;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instruction (instruction),
    .immediate   (dec_imm),
    .fmt         (dec_fmt),
    .illegal     (dec_illegal)
  );

  assign in_ready  = (state != SKID_FULL);
  assign out_valid = (state != SKID_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_next     = state;
    load_head_new  = 1'b0;
    load_skid      = 1'b0;
    load_head_skid = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (accept) begin
          state_next    = SKID_ONE;
          load_head_new = 1'b1;
        end
      end
      SKID_ONE: begin
        case ({accept, drain})
          2'b11: load_head_new = 1'b1;
          2'b01: state_next    = SKID_EMPTY;
          2'b10: begin
            state_next = SKID_FULL;
            load_skid  = 1'b1;
          end
          default: state_next = SKID_ONE;
        endcase
      end
      SKID_FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          state_next     = SKID_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SKID_EMPTY;
      immediate     <= '0;
      fmt           <= FMT_R;
      illegal       <= 1'b0;
      skid_imm      <= '0;
      skid_fmt      <= FMT_R;
      skid_illegal  <= 1'b0;
      illegal_count <= '0;
    end else begin
      state <= state_next;
      if (load_head_new) begin
        immediate <= dec_imm;
        fmt       <= dec_fmt;
        illegal   <= dec_illegal;
      end else if (load_head_skid) begin
        immediate <= skid_imm;
        fmt       <= skid_fmt;
        illegal   <= skid_illegal;
      end
      if (load_skid) begin
        skid_imm     <= dec_imm;
        skid_fmt     <= dec_fmt;
        skid_illegal <= dec_illegal;
      end
      if (accept && dec_illegal && (illegal_count != {CNT_W{1'b1}}))
        illegal_count <= illegal_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe (XLEN=64/CNT_W=16 and XLEN=32/CNT_W=2)
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instruction;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [63:0] a_imm;
  logic [2:0]  a_fmt;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_ill;
  logic [31:0] b_imm;
  logic [2:0]  b_fmt;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cnt_a_model = 0;
  int   cnt_b_model = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .instruction(instruction), .out_valid(a_out_valid), .out_ready(out_ready),
    .immediate(a_imm), .fmt(a_fmt), .illegal(a_ill), .illegal_count(a_cnt)
  );

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .instruction(instruction), .out_valid(b_out_valid), .out_ready(out_ready),
    .immediate(b_imm), .fmt(b_fmt), .illegal(b_ill), .illegal_count(b_cnt)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference decode using signed 64-bit arithmetic on the instruction word.
  function automatic exp_t model(input logic [31:0] ins);
    exp_t   e;
    int     si;
    longint sx, hi, f1, f2, f3, v;
    si = ins;
    sx = si;
    hi = sx >>> 31;
    v  = 0;
    e.fmt = 3'd7;
    e.ill = 1'b1;
    case (ins[6:0])
      7'h03, 7'h13, 7'h1b, 7'h67: begin
        e.fmt = 3'd1; e.ill = 1'b0;
        v = sx >>> 20;
      end
      7'h23: begin
        e.fmt = 3'd2; e.ill = 1'b0;
        f1 = ins[11:7];
        v = (sx >>> 25) * 32 + f1;
      end
      7'h63: begin
        e.fmt = 3'd3; e.ill = 1'b0;
        f1 = ins[7]; f2 = ins[30:25]; f3 = ins[11:8];
        v = hi * 4096 + f1 * 2048 + f2 * 32 + f3 * 2;
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4; e.ill = 1'b0;
        v = (sx >>> 12) * 4096;
      end
      7'h6f: begin
        e.fmt = 3'd5; e.ill = 1'b0;
        f1 = ins[19:12]; f2 = ins[20]; f3 = ins[30:21];
        v = hi * 1048576 + f1 * 4096 + f2 * 2048 + f3 * 2;
      end
      7'h33, 7'h3b: begin
        e.fmt = 3'd0; e.ill = 1'b0;
      end
      default: begin
        e.fmt = 3'd7; e.ill = 1'b1;
      end
    endcase
    e.imm = v;
    return e;
  endfunction

  // Monitor: the head must match the queue front whenever valid; pop on drain, push on accept.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      qa.delete();
      qb.delete();
      cnt_a_model = 0;
      cnt_b_model = 0;
    end else begin
      chk("a_count", {48'd0, a_cnt}, cnt_a_model);
      chk("b_count", {62'd0, b_cnt}, cnt_b_model);
      if (a_out_valid) begin
        if (qa.size() == 0) chk("a_unexpected_out", 64'd1, 64'd0);
        else begin
          chk("a_imm", a_imm, qa[0].imm);
          chk("a_fmt", {61'd0, a_fmt}, {61'd0, qa[0].fmt});
          chk("a_ill", {63'd0, a_ill}, {63'd0, qa[0].ill});
          if (out_ready) void'(qa.pop_front());
        end
      end
      if (b_out_valid) begin
        if (qb.size() == 0) chk("b_unexpected_out", 64'd1, 64'd0);
        else begin
          chk("b_imm", {32'd0, b_imm}, qb[0].imm);
          chk("b_fmt", {61'd0, b_fmt}, {61'd0, qb[0].fmt});
          if (out_ready) void'(qb.pop_front());
        end
      end
      if (in_valid && a_in_ready) begin
        e = model(instruction);
        qa.push_back(e);
        if (e.ill && cnt_a_model < 65535) cnt_a_model++;
      end
      if (in_valid && b_in_ready) begin
        e = model(instruction);
        e.imm = {32'd0, e.imm[31:0]};
        qb.push_back(e);
        if (e.ill && cnt_b_model < 3) cnt_b_model++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction into an empty pipe, result checked one edge later, then drained.
  task automatic directed(string name, input logic [31:0] ins, input logic [63:0] exp_imm,
                          input logic [2:0] exp_fmt);
    logic [63:0] e32;
    e32 = {32'd0, exp_imm[31:0]};
    instruction = ins;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    step();
    in_valid = 1'b0;
    chk({name, "_valid"}, {63'd0, a_out_valid}, 64'd1);
    chk({name, "_imm"}, a_imm, exp_imm);
    chk({name, "_fmt"}, {61'd0, a_fmt}, {61'd0, exp_fmt});
    chk({name, "_ill"}, {63'd0, a_ill}, {63'd0, (exp_fmt == 3'd7)});
    chk({name, "_imm32"}, {32'd0, b_imm}, e32);
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom % 14)
      0: op = 7'h03;  1: op = 7'h13;  2: op = 7'h1b;  3: op = 7'h67;
      4: op = 7'h23;  5: op = 7'h63;  6: op = 7'h37;  7: op = 7'h17;
      8: op = 7'h6f;  9: op = 7'h33;  10: op = 7'h3b;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  initial begin
    int n;
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    instruction = 32'd0;
    repeat (3) step();
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    chk("rst_imm", a_imm, 64'd0);
    chk("rst_fmt", {61'd0, a_fmt}, 64'd0);
    chk("rst_ill", {63'd0, a_ill}, 64'd0);
    chk("rst_cnt", {48'd0, a_cnt}, 64'd0);
    chk("rst_b_out_valid", {63'd0, b_out_valid}, 64'd0);
    reset = 1'b0;
    step();

    directed("addi", 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
    directed("sd",   32'hFE20BC23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2);
    directed("beq",  32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3);
    directed("lui",  32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4);
    directed("jal",  32'h001000EF, 64'h0000_0000_0000_0800, 3'd5);
    chk("cnt_before_bad", {48'd0, a_cnt}, 64'd0);
    directed("bad0", 32'h00000000, 64'd0, 3'd7);
    chk("cnt_after_bad", {48'd0, a_cnt}, 64'd1);
    chk("cnt2_after_bad", {62'd0, b_cnt}, 64'd1);
    for (int i = 0; i < 4; i++) directed("badx", ($urandom & 32'hFFFF_FFFC), 64'd0, 3'd7);
    chk("cnt_five", {48'd0, a_cnt}, 64'd5);
    chk("cnt2_sat", {62'd0, b_cnt}, 64'd3);

    // Back-pressure: two accepts fill the buffer, third is held off.
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'hFFF00093;
    step();
    chk("bp_ready1", {63'd0, a_in_ready}, 64'd1);
    instruction = 32'h001000EF;
    step();
    chk("bp_full_ready", {63'd0, a_in_ready}, 64'd0);
    chk("bp_head1", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    instruction = 32'h800000B7;
    step();
    chk("bp_full_ready2", {63'd0, a_in_ready}, 64'd0);
    chk("bp_head2", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    out_ready = 1'b1;
    step();
    chk("bp_drain1", a_imm, 64'h800);
    step();
    chk("bp_drain2", a_imm, 64'hFFFF_FFFF_8000_0000);
    in_valid = 1'b0;
    step();
    chk("bp_empty", {63'd0, a_out_valid}, 64'd0);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom % 4) != 0;
      out_ready   = ($urandom % 3) != 0;
      instruction = rand_instr();
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
      step();
      n++;
    end
    chk("drain_done", qa.size() + qb.size(), 64'd0);

    // Reset while FULL.
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'h00000000;
    step();
    step();
    chk("pre_rst_full", {63'd0, a_in_ready}, 64'd0);
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    chk("midrst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, a_in_ready}, 64'd1);
    chk("midrst_cnt", {48'd0, a_cnt}, 64'd0);
    chk("midrst_b_cnt", {62'd0, b_cnt}, 64'd0);
    chk("midrst_b_out_valid", {63'd0, b_out_valid}, 64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    chk("post_rst_no_stale", {63'd0, a_out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
